// File: rtl/uart_rx_ctrl_if.sv
// ============================================================================
// uart_rx_ctrl_if : serial line, shift-register and host signals of the UART RX control stage
// Revision 1.0
// ============================================================================
`default_nettype none

interface uart_rx_ctrl_if;
  logic       serial_in;
  logic [7:0] packet_data;
  logic       stop_bit;
  logic       data_read;
  logic       shift_strobe;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       rx_busy;

  modport master (
    output serial_in, packet_data, stop_bit, data_read,
    input  shift_strobe, rx_data, data_ready, overrun_error, framing_error, rx_busy
  );

  modport slave (
    input  serial_in, packet_data, stop_bit, data_read,
    output shift_strobe, rx_data, data_ready, overrun_error, framing_error, rx_busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// uart_rx_ctrl : start-bit validation, bit-centre shift strobes, receive buffer and error flags
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic          clk,
  input  logic          n_rst,
  uart_rx_ctrl_if.slave bus
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] C_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] C_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] C_PRE  = TW'(CLKS_PER_BIT - 2);
  localparam logic [TW-1:0] C_ONE  = TW'(1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START_CHK = 2'd1;
  localparam logic [1:0] RECV      = 2'd2;
  localparam logic [1:0] STOP_CHK  = 2'd3;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_bit_cnt;
  logic          r_strobe;
  logic          r_busy;
  logic [7:0]    r_rx_data;
  logic          r_ready;
  logic          r_overrun;
  logic          r_framing;

  logic w_rx_s;
  logic w_start_edge;
  logic w_at_half;
  logic w_bit_end;
  logic w_start_ok;
  logic w_load;
  logic w_frame_bad;

  assign w_rx_s       = r_sync2;
  assign w_start_edge = r_prev & ~w_rx_s;
  assign w_at_half    = (r_timer == C_HALF);
  assign w_bit_end    = (r_timer == C_LAST);
  assign w_start_ok   = (r_state == START_CHK) && w_at_half && !w_rx_s;
  assign w_load       = (r_state == STOP_CHK) && bus.stop_bit;
  assign w_frame_bad  = (r_state == STOP_CHK) && !bus.stop_bit;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= bus.serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_start_edge) w_next = START_CHK;
      START_CHK: if (w_at_half) w_next = w_rx_s ? IDLE : RECV;
      RECV:      if (w_bit_end && (r_bit_cnt == 4'd8)) w_next = STOP_CHK;
      STOP_CHK:  w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Timer restarts on every state change and at each bit boundary in RECV,
  // so in RECV it reads N-1 exactly on the strobe cycles.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_cnt <= 4'd0;
      r_strobe  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_strobe <= (r_state == RECV) && (r_timer == C_PRE);
      r_busy   <= (w_next != IDLE);

      if (w_next != r_state)
        r_timer <= '0;
      else if ((r_state == RECV) && w_bit_end)
        r_timer <= '0;
      else if (r_state != IDLE)
        r_timer <= r_timer + C_ONE;
      else
        r_timer <= '0;

      if (r_state != RECV)
        r_bit_cnt <= 4'd0;
      else if (w_bit_end)
        r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  // A load coinciding with a host read keeps data_ready set and suppresses overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_data <= 8'h00;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_framing <= 1'b0;
    end else begin
      if (w_load) begin
        r_rx_data <= bus.packet_data;
        r_ready   <= 1'b1;
        r_overrun <= r_ready & ~bus.data_read;
      end else if (bus.data_read) begin
        r_ready   <= 1'b0;
        r_overrun <= 1'b0;
      end

      if (w_start_ok)
        r_framing <= 1'b0;
      else if (w_frame_bad)
        r_framing <= 1'b1;
    end
  end

  assign bus.shift_strobe  = r_strobe;
  assign bus.rx_data       = r_rx_data;
  assign bus.data_ready    = r_ready;
  assign bus.overrun_error = r_overrun;
  assign bus.framing_error = r_framing;
  assign bus.rx_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// tb_uart_rx_ctrl : directed bench for uart_rx_ctrl with a model 9-bit shift register
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

  localparam int N = 10;

  logic clk;
  logic n_rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [8:0] sr = '0;
  logic busy_q = 1'b0;
  int   strobe_log[$];
  int   busy_log[$];

  uart_rx_ctrl_if u_if ();

  uart_rx_ctrl #(.CLKS_PER_BIT(N)) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream receive shift register: samples the raw line on each strobe, LSB first.
  always @(posedge clk) if (u_if.shift_strobe) sr <= {u_if.serial_in, sr[8:1]};
  assign u_if.packet_data = sr[7:0];
  assign u_if.stop_bit    = sr[8];

  always @(negedge clk) begin
    if (u_if.shift_strobe === 1'b1) strobe_log.push_back(cyc);
    if (u_if.rx_busy !== busy_q) begin
      busy_log.push_back(cyc);
      busy_q <= u_if.rx_busy;
    end
  end

  // Raw line falls at t0, so T (first START_CHK cycle) is t0+3.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic rd_at_stop,
                            output int t0, output logic fe3, output logic fe9,
                            output logic rdy_pre, output logic busy_pre);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    @(posedge clk); #1;
    t0 = cyc;
    strobe_log.delete();
    busy_log.delete();
    for (int i = 0; i < 10; i++) begin
      u_if.serial_in = bits[i];
      if (i == 0) begin
        repeat (3) @(posedge clk); #1;
        fe3 = u_if.framing_error;
        repeat (6) @(posedge clk); #1;
        fe9 = u_if.framing_error;
        @(posedge clk); #1;
      end else if (i == 9) begin
        repeat (9) @(posedge clk); #1;
        rdy_pre  = u_if.data_ready;
        busy_pre = u_if.rx_busy;
        u_if.data_read = rd_at_stop;
        @(posedge clk); #1;
        u_if.data_read = 1'b0;
      end else begin
        repeat (10) @(posedge clk); #1;
      end
    end
    u_if.serial_in = 1'b1;
  endtask

  task automatic pulse_read();
    @(posedge clk); #1;
    u_if.data_read = 1'b1;
    @(posedge clk); #1;
    u_if.data_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    n_rst = 1'b0;
    u_if.serial_in = 1'b1;
    u_if.data_read = 1'b0;
    repeat (3) @(posedge clk); #1;
    obs = {u_if.shift_strobe, u_if.rx_data, u_if.data_ready, u_if.overrun_error,
           u_if.framing_error, u_if.rx_busy};
    n_cmp++;
    if (obs !== 13'h0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0000", obs); end
    n_rst = 1'b1;
    strobe_log.delete();
    busy_log.delete();
    repeat (20) @(posedge clk); #1;
    n_cmp++;
    if (strobe_log.size() + busy_log.size() != 0) begin
      n_err++; $display("FAIL reset_idle_activity: got %0d events expected 0",
                        strobe_log.size() + busy_log.size());
    end
  endtask

  task automatic test_good_frame();
    int t0; logic fe3, fe9, rp, bp;
    send_frame(8'hA5, 1'b1, 1'b0, t0, fe3, fe9, rp, bp);
    n_cmp++; if (u_if.rx_data !== 8'hA5) begin n_err++; $display("FAIL good_rx_data: got %h expected a5", u_if.rx_data); end
    n_cmp++; if (u_if.data_ready !== 1'b1) begin n_err++; $display("FAIL good_ready: got %b expected 1", u_if.data_ready); end
    n_cmp++; if (u_if.framing_error !== 1'b0) begin n_err++; $display("FAIL good_framing: got %b expected 0", u_if.framing_error); end
    n_cmp++; if (u_if.overrun_error !== 1'b0) begin n_err++; $display("FAIL good_overrun: got %b expected 0", u_if.overrun_error); end
    n_cmp++; if (u_if.rx_busy !== 1'b0) begin n_err++; $display("FAIL good_idle_at_T97: got %b expected 0", u_if.rx_busy); end
    n_cmp++; if ({rp, bp} !== 2'b01) begin n_err++; $display("FAIL good_stop_chk_cycle: got ready/busy %b expected 01", {rp, bp}); end
    repeat (5) @(posedge clk); #1;
    n_cmp++;
    if (strobe_log.size() != 9) begin
      n_err++; $display("FAIL good_strobe_count: got %0d expected 9", strobe_log.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        n_cmp++;
        if (strobe_log[k] != t0 + 18 + k * N) begin
          n_err++; $display("FAIL good_strobe_time[%0d]: got %0d expected %0d", k, strobe_log[k] - t0, 18 + k * N);
        end
      end
    end
    n_cmp++;
    if (busy_log.size() != 2 || busy_log[0] != t0 + 3 || busy_log[1] != t0 + 100) begin
      n_err++; $display("FAIL good_busy_window: got %0d events first %0d expected rise 3 fall 100",
                        busy_log.size(), (busy_log.size() > 0) ? busy_log[0] - t0 : -1);
    end
  endtask

  task automatic test_false_start();
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    strobe_log.delete();
    busy_log.delete();
    u_if.serial_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    u_if.serial_in = 1'b1;
    repeat (120) @(posedge clk); #1;
    n_cmp++; if (strobe_log.size() != 0) begin n_err++; $display("FAIL false_strobes: got %0d expected 0", strobe_log.size()); end
    n_cmp++;
    if (busy_log.size() != 2 || busy_log[0] != t0 + 3 || busy_log[1] != t0 + 9) begin
      n_err++; $display("FAIL false_busy_window: got %0d events expected rise 3 fall 9", busy_log.size());
    end
    n_cmp++;
    if ({u_if.rx_data, u_if.data_ready, u_if.overrun_error, u_if.framing_error} !== {8'hA5, 3'b100}) begin
      n_err++; $display("FAIL false_flags: got %h/%b%b%b expected a5/100", u_if.rx_data,
                        u_if.data_ready, u_if.overrun_error, u_if.framing_error);
    end
  endtask

  task automatic test_framing_error();
    int t0; logic fe3, fe9, rp, bp;
    pulse_read();
    n_cmp++; if ({u_if.data_ready, u_if.overrun_error} !== 2'b00) begin n_err++; $display("FAIL read_clear: got %b expected 00", {u_if.data_ready, u_if.overrun_error}); end
    send_frame(8'h3C, 1'b0, 1'b0, t0, fe3, fe9, rp, bp);
    n_cmp++; if (u_if.framing_error !== 1'b1) begin n_err++; $display("FAIL fe_set: got %b expected 1", u_if.framing_error); end
    n_cmp++; if (u_if.data_ready !== 1'b0) begin n_err++; $display("FAIL fe_ready: got %b expected 0", u_if.data_ready); end
    n_cmp++; if (u_if.rx_data !== 8'hA5) begin n_err++; $display("FAIL fe_rx_data: got %h expected a5", u_if.rx_data); end
    send_frame(8'h5A, 1'b1, 1'b0, t0, fe3, fe9, rp, bp);
    n_cmp++; if ({fe3, fe9} !== 2'b10) begin n_err++; $display("FAIL fe_clear_at_start_chk: got %b expected 10", {fe3, fe9}); end
    n_cmp++; if ({u_if.rx_data, u_if.data_ready, u_if.framing_error} !== {8'h5A, 2'b10}) begin
      n_err++; $display("FAIL fe_next_frame: got %h/%b%b expected 5a/10", u_if.rx_data, u_if.data_ready, u_if.framing_error);
    end
    pulse_read();
  endtask

  task automatic test_overrun();
    int t0; logic fe3, fe9, rp, bp;
    send_frame(8'h11, 1'b1, 1'b0, t0, fe3, fe9, rp, bp);
    n_cmp++; if ({u_if.rx_data, u_if.data_ready, u_if.overrun_error} !== {8'h11, 2'b10}) begin
      n_err++; $display("FAIL ovr_first: got %h/%b%b expected 11/10", u_if.rx_data, u_if.data_ready, u_if.overrun_error);
    end
    send_frame(8'h22, 1'b1, 1'b0, t0, fe3, fe9, rp, bp);
    n_cmp++; if ({u_if.rx_data, u_if.data_ready, u_if.overrun_error} !== {8'h22, 2'b11}) begin
      n_err++; $display("FAIL ovr_second: got %h/%b%b expected 22/11", u_if.rx_data, u_if.data_ready, u_if.overrun_error);
    end
    pulse_read();
    n_cmp++; if ({u_if.rx_data, u_if.data_ready, u_if.overrun_error} !== {8'h22, 2'b00}) begin
      n_err++; $display("FAIL ovr_read_clear: got %h/%b%b expected 22/00", u_if.rx_data, u_if.data_ready, u_if.overrun_error);
    end
  endtask

  task automatic test_back_to_back_collision();
    int t0; logic fe3, fe9, rp, bp;
    send_frame(8'h33, 1'b1, 1'b0, t0, fe3, fe9, rp, bp);
    send_frame(8'h44, 1'b1, 1'b1, t0, fe3, fe9, rp, bp);
    n_cmp++; if (rp !== 1'b1) begin n_err++; $display("FAIL coll_ready_before: got %b expected 1", rp); end
    n_cmp++; if ({u_if.rx_data, u_if.data_ready, u_if.overrun_error} !== {8'h44, 2'b10}) begin
      n_err++; $display("FAIL coll_load_wins: got %h/%b%b expected 44/10", u_if.rx_data, u_if.data_ready, u_if.overrun_error);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] obs;
    @(posedge clk); #1;
    u_if.serial_in = 1'b0;
    repeat (25) @(posedge clk); #1;
    u_if.serial_in = 1'b1;
    repeat (25) @(posedge clk); #1;
    n_cmp++; if (u_if.rx_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before_reset: got %b expected 1", u_if.rx_busy); end
    n_rst = 1'b0;
    #1;
    obs = {u_if.shift_strobe, u_if.rx_data, u_if.data_ready, u_if.overrun_error,
           u_if.framing_error, u_if.rx_busy};
    n_cmp++; if (obs !== 13'h0) begin n_err++; $display("FAIL mid_reset_outputs: got %h expected 0000", obs); end
    repeat (3) @(posedge clk); #1;
    n_rst = 1'b1;
    strobe_log.delete();
    busy_log.delete();
    repeat (120) @(posedge clk); #1;
    n_cmp++;
    if (strobe_log.size() + busy_log.size() != 0 || u_if.data_ready !== 1'b0 || u_if.rx_data !== 8'h00) begin
      n_err++; $display("FAIL mid_after_release: got %0d events ready %b data %h expected 0 events 0 00",
                        strobe_log.size() + busy_log.size(), u_if.data_ready, u_if.rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_false_start();
    test_framing_error();
    test_overrun();
    test_back_to_back_collision();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
